mul_seq_ctrl: RTL and testbench
===============================

// Module: mul_seq_ctrl
// PURPOSE
//  Multi-cycle unsigned multiplier controller for the R-type CPU execute stage.
//  It sequences one shared WIDTH-bit carry-lookahead adder through shift-add
//  iterations, one per cycle, so MUL needs no array multiplier.
//  It talks to the CPU control unit through a start/busy/done handshake.
// PARAMETERS
//  WIDTH  32             operand width in bits; must be >= 2
//  CNT_W  $clog2(WIDTH)  iteration counter width
// PORTS
//  clk    in   1        rising-edge clock
//  rst    in   1        asynchronous reset, active-high
//  start  in   1        request a multiply; sampled only when the block is ready
//  a      in   WIDTH    multiplicand, captured on an accepted start
//  b      in   WIDTH    multiplier, captured on an accepted start
//  busy   out  1        1 while in RUN
//  done   out  1        one-cycle pulse; prod is valid from this cycle onward
//  prod   out  2*WIDTH  product {hi,lo}; held until the next accepted start
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, cnt=0, mcand=0, acc=0, busy=0, done=0, prod=0.
//  Registers:
//   - mcand[WIDTH-1:0]
//   - acc[2*WIDTH-1:0]: hi = acc[2W-1:W], lo = acc[W-1:0]
//   - cnt[CNT_W-1:0]
//   - state
//  FSM states: IDLE, RUN, DONE.
//   - IDLE: if start, then mcand<=a, acc<={W'b0,b}, cnt<=0, go to RUN.
//   - RUN, each cycle:
//     - adder inputs: A=hi, B=(lo[0] ? mcand : 0), Cin=0. Sum is F, carry-out is Co.
//     - acc <= {Co, F, lo[W-1:1]}, a logical right shift that includes the carry.
//     - if cnt==WIDTH-1, go to DONE; else cnt<=cnt+1.
//   - DONE: done=1 for exactly this cycle.
//     - if start, accept it exactly as in IDLE and go to RUN (back-to-back).
//     - else go to IDLE.
//  Outputs:
//   - prod = acc. It is architecturally meaningful only from done onward.
//   - busy = (state==RUN), decoded from state.
//   - done = (state==DONE).
//  Latency: start accepted at edge E0; done is high in the cycle after edge E0+WIDTH.
//   For WIDTH=32: start seen in cycle 0, RUN in cycles 1..32, done in cycle 33.
//  start while RUN is ignored; a and b are not re-captured.
//  Arithmetic:
//   - the product is exact modulo 2^(2W); no overflow is possible.
//   - the shift carries Co into bit 2W-1, which equals the true (W+1)-bit partial sum.
//  Zero operands: no early termination. The block always takes WIDTH RUN cycles.
//  Reset asserted mid-RUN: the operation is abandoned, all outputs return to their
//   reset values, and no done is produced.
//  start held high continuously: the block restarts from DONE every WIDTH+1 cycles,
//   and each done pulse remains a single cycle.
// STRUCTURE
//  Shared package cpu_alu_pkg:
//   - localparam WORD_W=32
//   - typedef enum logic [1:0] {MS_IDLE, MS_RUN, MS_DONE} mul_state_t
//  Sub-module cla_add32:
//   - the team's combinational 32-bit carry-lookahead adder: A, B, Cin -> F, Cout.
//   - instantiate it once and keep it purely combinational.
//   - this block contains no "+" on the datapath; the counter increment is exempt.
//  Everything else is flat: one always_ff with async reset, one comb block for the
//   next-state logic and the adder operand mux.
// TESTING  (WIDTH=32)
//  1. rst pulse, then a=3, b=5, start for 1 cycle.
//     Required: busy=1 for 32 cycles, done in cycle 33, prod=64'h0F, busy=0 with done.
//  2. a=b=32'hFFFF_FFFF.
//     Required: prod=64'hFFFF_FFFE_0000_0001; checks the Co propagation into hi.
//  3. a=32'h1234_5678, b=0, then a=0, b=32'hDEAD_BEEF.
//     Required: both give prod=0, each still after 33 cycles.
//  4. Start 7*9. Pulse start with a=b=100 at RUN cycle 10.
//     Required: ignored; prod=63 at done, and no second done follows.
//  5. Start 0x10000*0x10000. Assert rst asynchronously (mid-cycle) at RUN cycle 16.
//     Required: busy/done/prod drop to 0 immediately and stay 0.
//     Then a clean 2*2 after release: prod=4.
//  6. Hold start high with a=6, b=7, then change to a=8, b=9 in the DONE cycle.
//     Required: done pulses at cycles 33 and 66. prod is 42, then 72.
//     done is never high for two consecutive cycles.
//  Scoreboard: compare every done-cycle prod against {32'b0,a}*{32'b0,b}.
//  Also run 1000 random operand pairs with random start gaps 0..3.

Source files
------------

// File: rtl/cpu_alu_pkg.sv
// Shared execute-stage ALU definitions: machine word width and multiplier
// sequencer state encoding.
package cpu_alu_pkg;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {MS_IDLE, MS_RUN, MS_DONE} mul_state_t;
endpackage

// File: rtl/cla_add32.sv
// Combinational carry-lookahead adder (parallel-prefix carry tree) with
// carry-in and carry-out. Defaults to the machine word width.
module cla_add32
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] f,
  output logic             cout
);
  localparam int LVL = $clog2(WIDTH);

  logic [WIDTH-1:0] p0, g0, gf;

  assign p0 = a ^ b;
  // Folding cin into bit 0 makes every prefix generate a true carry-out.
  assign g0 = (a & b) | {{(WIDTH-1){1'b0}}, p0[0] & cin};

  genvar lv;
  for (lv = 0; lv < LVL; lv++) begin : g_lvl
    localparam int D = 1 << lv;
    logic [WIDTH-1:0] gi, pv, gn;
    if (lv == 0) begin : g_src0
      assign gi = g0;
      assign pv = p0;
    end else begin : g_srcn
      assign gi = g_lvl[lv-1].gn;
      assign pv = g_lvl[lv-1].g_p.pn;
    end
    assign gn = gi | (pv & {gi[WIDTH-1-D:0], {D{1'b0}}});
    if (lv < LVL-1) begin : g_p
      logic [WIDTH-1:0] pn;
      assign pn = pv & {pv[WIDTH-1-D:0], {D{1'b1}}};
    end
  end

  assign gf   = g_lvl[LVL-1].gn;
  assign f    = p0 ^ {gf[WIDTH-2:0], cin};
  assign cout = gf[WIDTH-1];
endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential shift-add unsigned multiplier: one shared CLA adder iterated
// WIDTH times, start/busy/done handshake toward the CPU control unit.
module mul_seq_ctrl
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);

  mul_state_t         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0]   mcand, mcand_nxt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   add_b, sum;
  logic               co;

  cla_add32 #(.WIDTH(WIDTH)) u_add (
    .a    (acc[2*WIDTH-1:WIDTH]),
    .b    (add_b),
    .cin  (1'b0),
    .f    (sum),
    .cout (co)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mcand_nxt = mcand;
    acc_nxt   = acc;
    add_b     = acc[0] ? mcand : '0;
    case (state)
      MS_RUN: begin
        // Carry-out lands in the top bit so the partial sum never overflows.
        acc_nxt = {co, sum, acc[WIDTH-1:1]};
        if (cnt == LAST) state_nxt = MS_DONE;
        else             cnt_nxt   = cnt + 1'b1;
      end
      MS_IDLE, MS_DONE: begin
        state_nxt = MS_IDLE;
        if (start) begin
          mcand_nxt = a;
          acc_nxt   = {{WIDTH{1'b0}}, b};
          cnt_nxt   = '0;
          state_nxt = MS_RUN;
        end
      end
      default: state_nxt = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MS_IDLE;
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      mcand <= mcand_nxt;
      acc   <= acc_nxt;
    end
  end

  assign busy = (state == MS_RUN);
  assign done = (state == MS_DONE);
  assign prod = acc;
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed scenarios plus randomized
// operands scored against plain 64-bit multiplication.
module tb_mul_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [63:0] prod;

  int n_chk = 0;
  int n_pass = 0;

  mul_seq_ctrl #(.WIDTH(32)) dut (
    .clk (clk), .rst (rst), .start (start), .a (a), .b (b),
    .busy (busy), .done (done), .prod (prod)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    return {32'b0, x} * {32'b0, y};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Pulses start for one cycle and waits (bounded) for done; lat counts edges
  // after the accepting edge, -1 on timeout.
  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb,
                        output int bcnt, output int lat,
                        output logic [63:0] p, output logic bd);
    bcnt = 0; lat = -1; p = 'x; bd = 1'bx;
    a = xa; b = xb; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      if (busy) bcnt++;
      step();
      if (done) begin lat = k; p = prod; bd = busy; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_chk++; if (prod !== 64'h0) $display("FAIL reset_prod: got %h want 0", prod); else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int bc, lat; logic [63:0] p; logic bd;
    run_op(32'd3, 32'd5, bc, lat, p, bd);
    n_chk++; if (bc !== 32) $display("FAIL basic_busy_cycles: got %0d want 32", bc); else n_pass++;
    n_chk++; if (lat !== 32) $display("FAIL basic_latency: got %0d want 32", lat); else n_pass++;
    n_chk++; if (p !== 64'h0F) $display("FAIL basic_prod: got %h want %h", p, 64'h0F); else n_pass++;
    n_chk++; if (bd !== 1'b0) $display("FAIL basic_busy_at_done: got %b want 0", bd); else n_pass++;
    step();
    n_chk++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done); else n_pass++;
    n_chk++; if (prod !== 64'h0F) $display("FAIL basic_prod_held: got %h want %h", prod, 64'h0F); else n_pass++;
  endtask

  task automatic test_max();
    int bc, lat; logic [63:0] p; logic bd;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, lat, p, bd);
    n_chk++; if (p !== 64'hFFFF_FFFE_0000_0001) $display("FAIL max_prod: got %h want %h", p, 64'hFFFF_FFFE_0000_0001); else n_pass++;
    n_chk++; if (lat !== 32) $display("FAIL max_latency: got %0d want 32", lat); else n_pass++;
  endtask

  task automatic test_zero();
    int bc, lat; logic [63:0] p; logic bd;
    run_op(32'h1234_5678, 32'h0, bc, lat, p, bd);
    n_chk++; if (p !== 64'h0) $display("FAIL zero_b_prod: got %h want 0", p); else n_pass++;
    n_chk++; if (lat !== 32) $display("FAIL zero_b_latency: got %0d want 32", lat); else n_pass++;
    step();
    run_op(32'h0, 32'hDEAD_BEEF, bc, lat, p, bd);
    n_chk++; if (p !== 64'h0) $display("FAIL zero_a_prod: got %h want 0", p); else n_pass++;
    n_chk++; if (lat !== 32) $display("FAIL zero_a_latency: got %0d want 32", lat); else n_pass++;
  endtask

  task automatic test_ignore_start();
    int ndone = 0, lat = -1;
    logic [63:0] p = 'x;
    a = 32'd7; b = 32'd9; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 10) begin start = 1'b1; a = 32'd100; b = 32'd100; end
      else start = 1'b0;
      step();
      if (done) begin
        ndone++;
        if (lat < 0) begin lat = k; p = prod; end
      end
    end
    n_chk++; if (p !== 64'd63) $display("FAIL ignore_prod: got %h want %h", p, 64'd63); else n_pass++;
    n_chk++; if (lat !== 32) $display("FAIL ignore_latency: got %0d want 32", lat); else n_pass++;
    n_chk++; if (ndone !== 1) $display("FAIL ignore_done_count: got %0d want 1", ndone); else n_pass++;
  endtask

  task automatic test_abort();
    int bc, lat, bad = 0; logic [63:0] p; logic bd;
    a = 32'h10000; b = 32'h10000; start = 1'b1;
    step();
    start = 1'b0;
    repeat (15) step();
    #3 rst = 1'b1;
    #1;
    n_chk++; if ({busy, done} !== 2'b00) $display("FAIL abort_flags: got %b want 00", {busy, done}); else n_pass++;
    n_chk++; if (prod !== 64'h0) $display("FAIL abort_prod: got %h want 0", prod); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      step();
      if (busy !== 1'b0 || done !== 1'b0 || prod !== 64'h0) bad++;
    end
    n_chk++; if (bad !== 0) $display("FAIL abort_hold: got %0d nonzero cycles want 0", bad); else n_pass++;
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_chk++; if (bad !== 0) $display("FAIL abort_no_done: got %0d active cycles want 0", bad); else n_pass++;
    run_op(32'd2, 32'd2, bc, lat, p, bd);
    n_chk++; if (p !== 64'd4) $display("FAIL abort_recover_prod: got %h want %h", p, 64'd4); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nd = 0, d1 = -1, d2 = -1, dbl = 0;
    logic [63:0] p1 = 'x, p2 = 'x;
    logic prev = 1'b0;
    a = 32'd6; b = 32'd7; start = 1'b1;
    step();
    for (int k = 1; k <= 75; k++) begin
      step();
      if (done && prev) dbl++;
      prev = done;
      if (done) begin
        nd++;
        if (nd == 1) begin d1 = k; p1 = prod; a = 32'd8; b = 32'd9; end
        else if (nd == 2) begin d2 = k; p2 = prod; start = 1'b0; end
      end
    end
    start = 1'b0;
    n_chk++; if (d1 !== 32) $display("FAIL b2b_first_done: got %0d want 32", d1); else n_pass++;
    n_chk++; if (d2 !== 65) $display("FAIL b2b_second_done: got %0d want 65", d2); else n_pass++;
    n_chk++; if (p1 !== ref_mul(32'd6, 32'd7)) $display("FAIL b2b_prod1: got %h want %h", p1, ref_mul(32'd6, 32'd7)); else n_pass++;
    n_chk++; if (p2 !== ref_mul(32'd8, 32'd9)) $display("FAIL b2b_prod2: got %h want %h", p2, ref_mul(32'd8, 32'd9)); else n_pass++;
    n_chk++; if (dbl !== 0) $display("FAIL b2b_double_done: got %0d want 0", dbl); else n_pass++;
    n_chk++; if (nd !== 2) $display("FAIL b2b_done_count: got %0d want 2", nd); else n_pass++;
  endtask

  task automatic test_random();
    int bc, lat; logic [63:0] p; logic bd;
    logic [31:0] xa, xb;
    for (int i = 0; i < 1000; i++) begin
      xa = $urandom();
      xb = $urandom();
      if (i % 50 == 0) xa = 32'hFFFF_FFFF;
      if (i % 70 == 0) xb = 32'h0;
      repeat ($urandom_range(0, 3)) step();
      run_op(xa, xb, bc, lat, p, bd);
      n_chk++;
      if (p !== ref_mul(xa, xb) || lat !== 32)
        $display("FAIL rand_op %0d: a=%h b=%h got %h lat %0d want %h lat 32", i, xa, xb, p, lat, ref_mul(xa, xb));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    step(); step();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
